// File: rtl/sgd_x_updated_drain_if.sv
// Bundles the BRAM read port and the row output stream of the x_updated drain.
//   master : drain side (drives read address and output stream, takes read data and ready)
//   slave  : environment side (BRAM model plus downstream consumer)
interface sgd_x_updated_drain_if #(
  parameter int unsigned LANES       = 8,
  parameter int unsigned X_BIT_DEPTH = 10
);
  logic [X_BIT_DEPTH-1:0] x_updated_rd_addr;
  logic [LANES*32-1:0]    x_updated_rd_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*32-1:0]    out_data;
  logic                   out_last;

  modport master (
    output x_updated_rd_addr,
    input  x_updated_rd_data,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_last
  );

  modport slave (
    input  x_updated_rd_addr,
    output x_updated_rd_data,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_last
  );
endinterface

// File: rtl/sgd_x_updated_drain.sv
// Streams the x_updated model out of its BRAM bank, one LANES-wide row per transfer.
// Reads are credit-limited so every in-flight BRAM read has a guaranteed FIFO slot,
// which keeps the stream lossless under any backpressure pattern.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : drain request, honoured only while idle
//   dimension  : model size in elements, sampled with an accepted start
//   bus_io     : BRAM read port plus valid/ready row stream with last flag
//   busy       : high whenever not idle
//   done       : one-cycle pulse when a drain completes
module sgd_x_updated_drain #(
  parameter int unsigned LANES       = 8,
  parameter int unsigned X_BIT_DEPTH = 10,
  parameter int unsigned ROW_SHIFT   = 6,
  parameter int unsigned RD_LATENCY  = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [31:0]                  dimension,
  sgd_x_updated_drain_if.master        bus_io,
  output logic                         busy,
  output logic                         done
);

  localparam int unsigned DataW = LANES * 32;
  localparam int unsigned RowsW = X_BIT_DEPTH + 1;
  localparam int unsigned RawW  = 32 - ROW_SHIFT + 1;
  localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);
  localparam logic [RawW-1:0] MaxRows = RawW'(1) << X_BIT_DEPTH;

  typedef enum logic [1:0] {StIdle, StLoad, StStream, StDone} state_e;

  state_e state_q, state_d;

  logic [RowsW-1:0]       rows_q, rows_sat;
  logic [RowsW-1:0]       issued_q;
  logic [X_BIT_DEPTH-1:0] addr_q;
  logic [RD_LATENCY-1:0]  vld_q;
  logic [RD_LATENCY-1:0]  lst_q;
  logic [DataW-1:0]       mem_q [FIFO_DEPTH];
  logic                   mem_last_q [FIFO_DEPTH];
  logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]        fifo_cnt_q;
  logic [CntW-1:0]        inflight;
  logic [RawW-1:0]        raw_rows;
  logic                   accept, issue, issue_last, push, push_last, pop, head_last, fifo_nempty;

  // Row count rounds up a partial row and saturates at the bank depth.
  assign raw_rows = {1'b0, dimension[31:ROW_SHIFT]} + RawW'(|dimension[ROW_SHIFT-1:0]);
  assign rows_sat = (raw_rows > MaxRows) ? RowsW'(MaxRows) : RowsW'(raw_rows);

  assign accept = (state_q == StIdle) && start;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + CntW'(vld_q[i]);
    end
  end

  // Credit: queued plus in-flight rows never exceed FIFO capacity, so a push always fits.
  assign issue = (state_q == StStream) && (issued_q < rows_q) &&
                 (({1'b0, fifo_cnt_q} + {1'b0, inflight}) < (CntW + 1)'(FIFO_DEPTH));
  assign issue_last = (issued_q == rows_q - RowsW'(1));

  assign push        = vld_q[RD_LATENCY-1];
  assign push_last   = lst_q[RD_LATENCY-1];
  assign fifo_nempty = (fifo_cnt_q != '0);
  assign pop         = fifo_nempty && bus_io.out_ready;
  assign head_last   = mem_last_q[rd_ptr_q];

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StLoad;
      StLoad:   state_d = (rows_q != '0) ? StStream : StDone;
      StStream: if (pop && head_last) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q != StIdle);
    done = (state_q == StDone);
  end

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FIFO_DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      rows_q     <= '0;
      issued_q   <= '0;
      addr_q     <= '0;
      vld_q      <= '0;
      lst_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (accept) begin
        rows_q   <= rows_sat;
        issued_q <= '0;
        addr_q   <= '0;
      end else if (issue) begin
        issued_q <= issued_q + RowsW'(1);
        addr_q   <= addr_q + X_BIT_DEPTH'(1);
      end

      // Valid/last delay line tracks each read until its data returns.
      vld_q[0] <= issue;
      lst_q[0] <= issue && issue_last;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        lst_q[i] <= lst_q[i-1];
      end

      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);

      unique case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CntW'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CntW'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  // Storage needs no reset: the head is only exposed while the count is non-zero.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q]      <= bus_io.x_updated_rd_data;
      mem_last_q[wr_ptr_q] <= push_last;
    end
  end

  always_comb begin
    bus_io.x_updated_rd_addr = addr_q;
    bus_io.out_valid         = fifo_nempty;
    bus_io.out_data          = fifo_nempty ? mem_q[rd_ptr_q] : '0;
    bus_io.out_last          = fifo_nempty && head_last;
  end

endmodule

// File: tb/tb_sgd_x_updated_drain.sv
// Directed bench for sgd_x_updated_drain with a BRAM model of fixed read latency.
module tb_sgd_x_updated_drain;
  localparam int unsigned LANES  = 8;
  localparam int unsigned XBD    = 10;
  localparam int unsigned DataW  = LANES * 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] dimension;
  logic        busy, done;

  int checks = 0;
  int errors = 0;

  sgd_x_updated_drain_if #(.LANES(LANES), .X_BIT_DEPTH(XBD)) bus_if ();

  sgd_x_updated_drain #(
    .LANES       (LANES),
    .X_BIT_DEPTH (XBD),
    .ROW_SHIFT   (6),
    .RD_LATENCY  (2),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dimension (dimension),
    .bus_io    (bus_if),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic logic [DataW-1:0] row_word(input logic [XBD-1:0] a);
    logic [DataW-1:0] w;
    for (int l = 0; l < LANES; l++) begin
      w[l*32 +: 32] = 32'hA500_0000 | (32'(l) << 16) | 32'(a);
    end
    return w;
  endfunction

  // BRAM model: two-cycle address-to-data latency.
  logic [XBD-1:0] a_p1, a_p2;
  always @(posedge clk) begin
    a_p1 <= bus_if.x_updated_rd_addr;
    a_p2 <= a_p1;
  end
  assign bus_if.x_updated_rd_data = row_word(a_p2);

  task automatic chk(input string tag, input logic [DataW-1:0] obs, input logic [DataW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drain(input logic [31:0] dim, input int exp_rows, input int ready_pct,
                       input int stall_at, input int busy_start_at, input bit check_lat);
    int idx = 0, cyc = 0, last_cyc = -1, first_cyc = -1, stall_cnt = 0;
    int limit = 40 * exp_rows + 100;
    bit seen_done = 0, hold = 0, held_last = 0;
    logic [DataW-1:0] held = '0;
    @(negedge clk);
    start = 1'b1; dimension = dim; bus_if.out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; cyc = 1;
    while (!seen_done && cyc < limit) begin
      if (stall_at >= 0 && idx == stall_at && stall_cnt < 20) begin
        bus_if.out_ready = 1'b0;
        stall_cnt++;
      end else begin
        bus_if.out_ready = ($urandom_range(99) < ready_pct);
      end
      if (cyc == busy_start_at) begin
        start = 1'b1; dimension = 32'd1024;
      end else begin
        start = 1'b0;
      end
      chk("busy_during_drain", busy, 1);
      chk("fifo_bound", 32'(dut.fifo_cnt_q <= 4), 1);
      if (hold) begin
        chk("hold_valid", bus_if.out_valid, 1);
        chk("hold_data", bus_if.out_data, held);
        chk("hold_last", bus_if.out_last, held_last);
      end
      if (done) begin
        chk("done_cycle", cyc, (exp_rows == 0) ? 2 : last_cyc + 1);
        chk("rows_at_done", idx, exp_rows);
        seen_done = 1;
      end
      if (bus_if.out_valid && bus_if.out_ready) begin
        if (idx < exp_rows) begin
          chk("row_data", bus_if.out_data, row_word(XBD'(idx)));
          chk("row_last", bus_if.out_last, (idx == exp_rows - 1));
        end else begin
          chk("extra_row", idx, exp_rows);
        end
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        idx++;
      end
      hold      = bus_if.out_valid && !bus_if.out_ready;
      held      = bus_if.out_data;
      held_last = bus_if.out_last;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("done_seen", seen_done, 1);
    chk("row_count", idx, exp_rows);
    if (check_lat && exp_rows > 0) begin
      chk("first_latency", first_cyc, 5);
      chk("throughput", last_cyc, 5 + exp_rows - 1);
    end
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_valid", bus_if.out_valid, 0);
  endtask

  initial begin
    int n, guard;
    rst = 1'b1; start = 1'b0; dimension = '0; bus_if.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_addr", bus_if.x_updated_rd_addr, 0);
    chk("rst_valid", bus_if.out_valid, 0);
    chk("rst_last", bus_if.out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_data", bus_if.out_data, 0);
    rst = 1'b0;

    drain(32'd256, 4, 100, -1, -1, 1'b1);
    drain(32'd65, 2, 100, -1, -1, 1'b1);
    drain(32'd0, 0, 100, -1, -1, 1'b0);
    drain(32'd1024, 16, 30, -1, -1, 1'b0);
    drain(32'd1024, 16, 100, 6, -1, 1'b0);
    drain(32'd256, 4, 100, -1, 4, 1'b1);

    // Abort a 16-row drain after 5 rows, then verify a clean restart.
    @(negedge clk);
    start = 1'b1; dimension = 32'd1024; bus_if.out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0; guard = 0;
    while (n < 5 && guard < 100) begin
      if (bus_if.out_valid) n++;
      if (n < 5) @(negedge clk);
      guard++;
    end
    chk("abort_reached", n, 5);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_addr", bus_if.x_updated_rd_addr, 0);
    chk("abort_valid", bus_if.out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_data", bus_if.out_data, 0);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_stale", bus_if.out_valid, 0);
    end
    drain(32'd128, 2, 100, -1, -1, 1'b1);

    drain(32'hFFFF_FFFF, 1024, 100, -1, -1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sgd_x_updated_drain.md
SGD_X_UPDATED_DRAIN -- requirements
Module: sgd_x_updated_drain

Interface
REQ-001 SHALL have parameter LANES, default 8: number of 32-bit words per x_updated bank row.
REQ-002 SHALL have parameter X_BIT_DEPTH, default 10: x_updated row address width.
REQ-003 SHALL have parameter ROW_SHIFT, default 6: log2 of model elements per row across all engines; used to convert dimension to a row count.
REQ-004 SHALL have parameter RD_LATENCY, default 2: fixed BRAM read latency in cycles, from address to data.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4: output buffer depth in rows; FIFO_DEPTH SHALL be at least RD_LATENCY+1.
REQ-006 clk  in  1  sole clock; all logic on its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 start  in  1  single-cycle request to drain the model; sampled only in IDLE.
REQ-009 dimension  in  32  model dimension in elements; sampled on the accepted start.
REQ-010 x_updated_rd_addr  out  X_BIT_DEPTH  BRAM read address.
REQ-011 x_updated_rd_data  in  LANES*32  BRAM read data, valid RD_LATENCY cycles after the address.
REQ-012 out_valid  out  1  out_data is valid.
REQ-013 out_ready  in  1  downstream accepts the word; a transfer occurs when out_valid and out_ready are both high.
REQ-014 out_data  out  LANES*32  one x_updated row; lane i occupies bits [(i+1)*32-1 : i*32].
REQ-015 out_last  out  1  high with the final row of a drain.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  single-cycle pulse when a drain completes.

Function
REQ-018 SHALL compute rows = dimension[31:ROW_SHIFT] + (dimension[ROW_SHIFT-1:0] != 0), registered in the cycle after start.
REQ-019 SHALL implement FSM IDLE -> LOAD on start; LOAD -> STREAM if rows != 0, else -> DONE; STREAM -> DONE on the transfer carrying out_last; DONE -> IDLE after one cycle.
REQ-020 done SHALL be high only in DONE; dimension=0 therefore produces done 2 cycles after start, with no output transfer.
REQ-021 start SHALL be ignored outside IDLE.
REQ-022 In STREAM, a read SHALL be issued in any cycle where issued < rows and (fifo_count + inflight) < FIFO_DEPTH; x_updated_rd_addr SHALL then increment.
REQ-023 Read addresses SHALL run 0 .. rows-1 in order; x_updated_rd_addr SHALL return to 0 on entry to LOAD.
REQ-024 A valid-delay pipeline of RD_LATENCY stages SHALL capture x_updated_rd_data into the FIFO exactly RD_LATENCY cycles after each issued read.
REQ-025 The credit rule SHALL guarantee that the FIFO never overflows and that no returning data is dropped under any out_ready pattern.
REQ-026 out_valid SHALL equal FIFO non-empty; out_data and out_last SHALL come from the FIFO head and SHALL remain stable while out_valid=1 and out_ready=0.
REQ-027 out_last SHALL be set on the row read from address rows-1 only.
REQ-028 With out_ready held high, the block SHALL sustain one row per cycle after an initial latency of RD_LATENCY+1 cycles from entry to STREAM.
REQ-029 A simultaneous FIFO push and pop SHALL leave fifo_count unchanged.
REQ-030 rows larger than 2^X_BIT_DEPTH SHALL be saturated to 2^X_BIT_DEPTH.

Reset
REQ-031 On rst, the FSM SHALL return to IDLE, and the FIFO, the in-flight pipeline, and the issued counter SHALL clear, including when rst is asserted mid-drain.
REQ-032 Reset values: x_updated_rd_addr=0, out_valid=0, out_last=0, busy=0, done=0, out_data=0.
REQ-033 The first accepted start after reset SHALL drain normally; no stale rows from the interrupted drain SHALL appear.

Verification
REQ-034 dimension=256, ROW_SHIFT=6, out_ready=1 -> 4 rows from addr 0..3; out_last on the 4th row; done one cycle after the last transfer.
REQ-035 dimension=65 -> rows=2; dimension=0 -> no out_valid, done 2 cycles after start.
REQ-036 rows=16, out_ready random at 30% -> all 16 rows in order, data matching the BRAM model, no loss or duplication, fifo_count<=4.
REQ-037 out_ready=0 for 20 cycles mid-drain -> out_data held stable, at most 4 rows outstanding, and the stream resumes correctly.
REQ-038 rst asserted at row 5 of 16, then start with dimension=128 -> exactly 2 fresh rows, addr 0..1, out_last on the 2nd.
REQ-039 start pulsed while busy -> ignored; the current drain count is unchanged.
